cgra_io_wrapper: RTL and testbench
==================================

Name: cgra_io_wrapper

Overview:
- Per-port latency-balancing shim between the banked register file and the CGRA edge I/O.
- Input path: RF read data is delayed by a per-port, run-time-programmable number of cycles, then driven into the CGRA edge inputs.
- Output path: CGRA edge outputs and their predicates are delayed by a per-port programmable amount, then driven to RF write data and write enables.
- Aligns operands and results of different ports so that all ports see the same thread on the same cycle.

Parameters:
- NUM_PORTS, 16, number of independent edge ports (one per RF bank).
- WIDTH, 32, data width per port.
- MAX_PIPE_STAGE, 8, number of latency settings. Legal latency is 0..MAX_PIPE_STAGE-1. Latency field width LW = $clog2(MAX_PIPE_STAGE), which is 3 at the default.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- clr, input, 1, synchronous pipeline flush, same effect as rst.
- latency_in, input, NUM_PORTS*LW, per-port input-path delay; port p uses [p*LW +: LW].
- latency_out, input, NUM_PORTS*LW, per-port output-path delay; port p uses [p*LW +: LW].
- rf_rdata, input, NUM_PORTS*WIDTH, RF read data; port p uses [p*WIDTH +: WIDTH].
- cgra_in, output, NUM_PORTS*WIDTH, delayed rf_rdata to the CGRA edge inputs.
- cgra_out, input, NUM_PORTS*WIDTH, CGRA edge output data.
- cgra_pred_out, input, NUM_PORTS, CGRA edge output predicate, bit p for port p.
- rf_wdata, output, NUM_PORTS*WIDTH, delayed cgra_out to the RF.
- rf_wr_en, output, NUM_PORTS, delayed cgra_pred_out, used as the RF write enable per bank.

Behaviour:
- Ports are fully independent; no cross-port interaction.
- Each port has two shift chains of MAX_PIPE_STAGE-1 registers:
  - input chain carries WIDTH bits;
  - output chain carries WIDTH+1 bits (data plus predicate).
- Both chains shift every cycle unconditionally. There is no stall and no handshake.
- Stage 1 captures the raw input; stage k captures stage k-1.
- Output selection by latency L = the port's field:
  - L = 0: output is the raw input, combinational, zero cycles.
  - L >= 1: output is stage L, a registered value exactly L cycles old.
- Latency is effectively 1..MAX_PIPE_STAGE-1 cycles registered, or 0 combinational.
- Predicate travels in lockstep with its data in the output chain, so rf_wr_en[p] and rf_wdata[p] always refer to the same source cycle.
- rf_wdata is passed through regardless of the predicate; a 0 predicate only suppresses rf_wr_en.
- Reset or clr:
  - on a rising edge with rst=1 or clr=1, every chain register becomes 0;
  - for the next L cycles, ports with L >= 1 output cgra_in = 0, rf_wdata = 0, rf_wr_en = 0;
  - ports with L = 0 keep following their inputs combinationally, even while rst or clr is asserted.
- clr arriving mid-stream discards all in-flight data and predicates; no spurious writes are produced afterwards.
- A latency change takes effect combinationally on the same cycle. Chain contents are not flushed; the output retaps an existing stage.
- Latency values at or above MAX_PIPE_STAGE are not possible at the default. For non-power-of-two MAX_PIPE_STAGE they are clamped to MAX_PIPE_STAGE-1.
- rst and clr asserted together behave as a single flush.
- No X propagation from the chains after reset: all registers are reset.

Optional Feature:
- Macro CGRA_IO_WR_CNT_EN.
- Defined:
  - adds output port wr_count, 32 bits;
  - each cycle it increments by the popcount of rf_wr_en;
  - cleared to 0 by rst or clr;
  - wraps modulo 2^32;
  - updates on the same edge the enables are sampled.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and zero state:
  - Stimulus: rst for 2 cycles; all latencies 3; rf_rdata = all 0xFFFFFFFF.
  - Response: during and for 3 cycles after reset, cgra_in = 0 and rf_wr_en = 0; from cycle 4, cgra_in port 0 = 0xFFFFFFFF.
- Per-port latency:
  - Stimulus: latency_in ports 0/1/2/3 = 0/1/2/3; ramp rf_rdata[p] = cycle count n.
  - Response: cgra_in[p] equals n-p on every cycle.
- Output predicate alignment:
  - Stimulus: latency_out port 5 = 4; cgra_out[5] = 0x1234 with pred = 1 on cycle t only.
  - Response: rf_wdata[5] = 0x1234 and rf_wr_en[5] = 1 exactly at t+4; rf_wr_en[5] = 0 at all other cycles.
- Flush mid-stream:
  - Stimulus: latency_out = 7 on all ports; pred = 1 for 3 cycles; clr pulsed 2 cycles after the last pred.
  - Response: no rf_wr_en bit is ever asserted.
- Zero-latency passthrough:
  - Stimulus: latency = 0; cgra_out[0] = 0xDEADBEEF, pred = 1, with rst held high.
  - Response: same-cycle rf_wdata[0] = 0xDEADBEEF and rf_wr_en[0] = 1.
- CGRA_IO_WR_CNT_EN:
  - Stimulus: 4 ports with pred = 1 and latency 0 for 10 cycles.
  - Response: wr_count = 40; clr then returns it to 0.

Source files
------------

// File: rtl/cgra_io_wrapper.sv
// cgra_io_wrapper: per-port latency-balancing shim between the banked RF and
// the CGRA edge I/O. Each port delays RF read data into the fabric and delays
// fabric results (data + predicate) back to the RF write side. The delay is
// selected per port at run time. A latency of 0 is a combinational bypass.
// Optional feature macro: CGRA_IO_WR_CNT_EN adds a 32-bit wr_count output.
// This output accumulates the number of asserted rf_wr_en bits per cycle.
// MAX_PIPE_STAGE must be at least 2.
module cgra_io_wrapper #(
  parameter int NUM_PORTS      = 16,
  parameter int WIDTH          = 32,
  parameter int MAX_PIPE_STAGE = 8,
  localparam int LW            = $clog2(MAX_PIPE_STAGE),
  localparam int NS            = MAX_PIPE_STAGE - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [NUM_PORTS*LW-1:0]    latency_in,
  input  logic [NUM_PORTS*LW-1:0]    latency_out,
  input  logic [NUM_PORTS*WIDTH-1:0] rf_rdata,
  output logic [NUM_PORTS*WIDTH-1:0] cgra_in,
  input  logic [NUM_PORTS*WIDTH-1:0] cgra_out,
  input  logic [NUM_PORTS-1:0]       cgra_pred_out,
  output logic [NUM_PORTS*WIDTH-1:0] rf_wdata,
  output logic [NUM_PORTS-1:0]       rf_wr_en
`ifdef CGRA_IO_WR_CNT_EN
  ,
  output logic [31:0]                wr_count
`endif
);

  // Stage k of a chain lives at element k-1, so a latency L taps element L-1.
  logic [WIDTH-1:0] in_d  [NUM_PORTS][NS];
  logic [WIDTH-1:0] in_q  [NUM_PORTS][NS];
  // Output chain entries are {predicate, data} so both always come from the same source cycle.
  logic [WIDTH:0]   out_d [NUM_PORTS][NS];
  logic [WIDTH:0]   out_q [NUM_PORTS][NS];

  // Clamp a latency field to the deepest stage that exists.
  // The clamp only matters when MAX_PIPE_STAGE is not a power of two.
  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] l);
    if (l > LW'(NS)) return LW'(NS);
    return l;
  endfunction

  // Next-state of both chains: stage 1 takes the raw input, each later stage takes its predecessor.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_d[p][0]  = rf_rdata[p*WIDTH +: WIDTH];
      out_d[p][0] = {cgra_pred_out[p], cgra_out[p*WIDTH +: WIDTH]};
      for (int k = 1; k < NS; k++) begin
        in_d[p][k]  = in_q[p][k-1];
        out_d[p][k] = out_q[p][k-1];
      end
    end
  end

  // Chain registers shift every cycle. rst or clr empties them, which drops all in-flight predicates.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int k = 0; k < NS; k++) begin
          in_q[p][k]  <= '0;
          out_q[p][k] <= '0;
        end
      end
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
    end
  end

  // Output taps: latency 0 bypasses the chain combinationally, otherwise select stage L.
  always_comb begin
    logic [LW-1:0] sel_in;
    logic [LW-1:0] sel_out;
    logic [WIDTH:0] out_word;
    cgra_in  = '0;
    rf_wdata = '0;
    rf_wr_en = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_in  = clamp_lat(latency_in[p*LW +: LW]);
      sel_out = clamp_lat(latency_out[p*LW +: LW]);
      if (sel_in == '0) cgra_in[p*WIDTH +: WIDTH] = rf_rdata[p*WIDTH +: WIDTH];
      else              cgra_in[p*WIDTH +: WIDTH] = in_q[p][sel_in - LW'(1)];
      if (sel_out == '0) out_word = {cgra_pred_out[p], cgra_out[p*WIDTH +: WIDTH]};
      else               out_word = out_q[p][sel_out - LW'(1)];
      rf_wdata[p*WIDTH +: WIDTH] = out_word[WIDTH-1:0];
      rf_wr_en[p]                = out_word[WIDTH];
    end
  end

`ifdef CGRA_IO_WR_CNT_EN
  logic [31:0] wr_count_d;
  logic [31:0] wr_count_q;

  // Add this cycle's write-enable popcount; the counter wraps naturally at 2^32.
  always_comb begin
    wr_count_d = wr_count_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_count_d = wr_count_d + 32'(rf_wr_en[p]);
    end
  end

  // Counter register, flushed together with the chains.
  always_ff @(posedge clk) begin
    if (rst || clr) wr_count_q <= '0;
    else            wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_cgra_io_wrapper.sv
// Directed bench for cgra_io_wrapper at default parameters (16 ports, 32 bits, 8 stages).
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time unit after that.
module tb_cgra_io_wrapper;
  localparam int NP = 16;
  localparam int W  = 32;
  localparam int LW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [NP*LW-1:0]  latency_in;
  logic [NP*LW-1:0]  latency_out;
  logic [NP*W-1:0]   rf_rdata;
  logic [NP*W-1:0]   cgra_in;
  logic [NP*W-1:0]   cgra_out;
  logic [NP-1:0]     cgra_pred_out;
  logic [NP*W-1:0]   rf_wdata;
  logic [NP-1:0]     rf_wr_en;
`ifdef CGRA_IO_WR_CNT_EN
  logic [31:0]       wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  cgra_io_wrapper dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .latency_in    (latency_in),
    .latency_out   (latency_out),
    .rf_rdata      (rf_rdata),
    .cgra_in       (cgra_in),
    .cgra_out      (cgra_out),
    .cgra_pred_out (cgra_pred_out),
    .rf_wdata      (rf_wdata),
    .rf_wr_en      (rf_wr_en)
`ifdef CGRA_IO_WR_CNT_EN
    ,
    .wr_count      (wr_count)
`endif
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [NP*LW-1:0] lat_all(input logic [LW-1:0] v);
    return {NP{v}};
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [NP*W-1:0] obs, input logic [NP*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [W-1:0] n_w;
    logic [W-1:0] e;

    // Reset and zero state: latencies 3, all-ones read data, predicates set.
    rst = 1'b1; clr = 1'b0;
    latency_in = lat_all(3'd3); latency_out = lat_all(3'd3);
    rf_rdata = '1; cgra_out = '1; cgra_pred_out = '1;
    step();
    chk("rst_c1_cgra_in", cgra_in, '0);
    chk("rst_c1_wr_en", NP*W'(rf_wr_en), '0);
    step();
    chk("rst_c2_cgra_in", cgra_in, '0);
    rst = 1'b0;
    step();
    chk("post_rst1_cgra_in", cgra_in, '0);
    chk("post_rst1_wr_en", NP*W'(rf_wr_en), '0);
    step();
    chk("post_rst2_cgra_in", cgra_in, '0);
    step();
    chk("post_rst3_cgra_in", cgra_in, '1);
    chk("post_rst3_wr_en", NP*W'(rf_wr_en), NP*W'(16'hFFFF));
    chk("post_rst3_wdata", rf_wdata, '1);

    // Per-port input latency: ports 0..3 use 0..3, ramp data equals cycle count.
    latency_in = '0;
    latency_in[0*LW +: LW] = 3'd0;
    latency_in[1*LW +: LW] = 3'd1;
    latency_in[2*LW +: LW] = 3'd2;
    latency_in[3*LW +: LW] = 3'd3;
    for (int n = 0; n < 10; n++) begin
      n_w = W'(n);
      rf_rdata = {NP{n_w}};
      settle();
      chk("ramp_p0", NP*W'(cgra_in[0*W +: W]), NP*W'(n_w));
      if (n >= 1) chk("ramp_p1", NP*W'(cgra_in[1*W +: W]), NP*W'(n_w - 32'd1));
      if (n >= 2) chk("ramp_p2", NP*W'(cgra_in[2*W +: W]), NP*W'(n_w - 32'd2));
      exp_q.push_back(n_w);
      if (exp_q.size() == 4) begin
        e = exp_q.pop_front();
        chk("ramp_p3", NP*W'(cgra_in[3*W +: W]), NP*W'(e));
      end
      step();
    end
    // Latency change retaps existing stage 1 (holds 9) without flushing.
    rf_rdata = {NP{32'd10}};
    latency_in[3*LW +: LW] = 3'd1;
    settle();
    chk("retap_p3", NP*W'(cgra_in[3*W +: W]), NP*W'(32'd9));

    // Output predicate alignment on port 5 with latency 4.
    cgra_out = '0; cgra_pred_out = '0;
    latency_out = '0;
    latency_out[5*LW +: LW] = 3'd4;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cgra_out = '0; cgra_pred_out = '0;
      if (i == 2) begin
        cgra_out[5*W +: W] = 32'h0000_1234;
        cgra_pred_out[5] = 1'b1;
      end
      settle();
      chk("pred_align_en", NP*W'(rf_wr_en), (i == 6) ? NP*W'(16'h0020) : '0);
      if (i == 6) chk("pred_align_data", NP*W'(rf_wdata[5*W +: W]), NP*W'(32'h0000_1234));
      step();
    end

    // Mid-stream flush: latency 7 everywhere, clr 2 cycles after the last predicate.
    latency_out = lat_all(3'd7);
    cgra_pred_out = '0;
    clr = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      cgra_pred_out = (i < 3) ? '1 : '0;
      cgra_out = {NP{32'hA5A5_0000 + W'(i)}};
      clr = (i == 4);
      settle();
      chk("flush_no_wr", NP*W'(rf_wr_en), '0);
      step();
    end
    clr = 1'b0;

    // Zero-latency passthrough while rst is held high.
    latency_in = '0; latency_out = '0;
    rst = 1'b1;
    cgra_out = '0; cgra_out[0 +: W] = 32'hDEAD_BEEF;
    cgra_pred_out = 16'h0001;
    rf_rdata = '0; rf_rdata[0 +: W] = 32'hCAFE_F00D;
    settle();
    chk("l0_wdata", NP*W'(rf_wdata[0 +: W]), NP*W'(32'hDEAD_BEEF));
    chk("l0_wr_en", NP*W'(rf_wr_en), NP*W'(16'h0001));
    chk("l0_cgra_in", NP*W'(cgra_in[0 +: W]), NP*W'(32'hCAFE_F00D));
    step();
    chk("l0_rst_held_wdata", NP*W'(rf_wdata[0 +: W]), NP*W'(32'hDEAD_BEEF));
    chk("l0_rst_held_wr_en", NP*W'(rf_wr_en), NP*W'(16'h0001));
    rst = 1'b0;

`ifdef CGRA_IO_WR_CNT_EN
    // Write counter: 4 enabled ports at latency 0 for 10 cycles gives 40.
    cgra_pred_out = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("cnt_cleared", NP*W'(wr_count), '0);
    cgra_pred_out = 16'h000F;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) chk("cnt_mid", NP*W'(wr_count), NP*W'(32'd20));
    end
    cgra_pred_out = '0;
    settle();
    chk("cnt_40", NP*W'(wr_count), NP*W'(32'd40));
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("cnt_clr", NP*W'(wr_count), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
